host_bus_arb: RTL and testbench

- Two-master arbiter and sequencer in front of the host bus decoder.
- Lets a processor bridge (master 0) and an autonomous register sequencer (master 1) share the single host bus used by the host_ctrl and vid_imager register blocks.
- Runs one transfer at a time: one-cycle rd/wr strobe, read data captured after a fixed latency, one-cycle ack returned to the winning master.

---
 rtl/host_arb_pkg.sv | 21 ++
 rtl/host_arb_pick.sv | 32 +++
 rtl/host_bus_arb.sv | 190 +++++++++++++++++++
 tb/tb_host_bus_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_arb_pkg.sv
// rtl/host_arb_pkg.sv - shared encodings and constants for the host bus arbiter
// Purpose: FSM state encoding, master index constants and read-latency limits
//   shared by host_bus_arb and host_arb_pick.
// Ports: none (package).
package host_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Largest supported read latency; the latency counter is sized from it.
   localparam int RD_LAT_MAX = 7;
   localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/host_arb_pick.sv
// rtl/host_arb_pick.sv - combinational two-way winner select
// Purpose: picks the master to grant from the current requests. A lone
//   requester always wins. On contention the master that was not granted
//   last wins (round-robin), or with HOST_ARB_FIXED_PRIO_EN defined master 0
//   always wins.
// Ports: req[1:0] request per master (bit index = master index);
//   last_grant most recently granted master; winner selected master index,
//   meaningful only while at least one req bit is high.
module host_arb_pick
   import host_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       winner
);

   always_comb begin
      winner = last_grant;
      if (req == 2'b01) begin
         winner = M0;
      end else if (req == 2'b10) begin
         winner = M1;
      end else if (req == 2'b11) begin
`ifdef HOST_ARB_FIXED_PRIO_EN
         winner = M0;
`else
         winner = ~last_grant;
`endif
      end
   end

endmodule

// File: rtl/host_bus_arb.sv
// rtl/host_bus_arb.sv - two-master host bus arbiter and transfer sequencer
// Purpose: shares the host register bus between the processor bridge
//   (master 0) and the register sequencer (master 1). One transfer at a time:
//   one-cycle rd/wr strobe, read data captured RD_LAT cycles after the strobe,
//   one-cycle ack to the owning master.
// Ports: host_clk / host_rst_l clock and async active-low reset;
//   mN_req/mN_wr/mN_addr/mN_wr_data request side and mN_ack/mN_rd_data
//   completion side for each master; host_addr/host_wr_data/host_rd_en/
//   host_wr_en/host_rd_data bus side; arb_busy high outside IDLE; arb_owner
//   current or last granted master.
// Config: HOST_ARB_FIXED_PRIO_EN selects fixed priority (master 0 wins
//   contention) instead of round-robin.
module host_bus_arb
   import host_arb_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int AW     = 16,
   parameter int DW     = 16
) (
   input  logic          host_clk,
   input  logic          host_rst_l,
   input  logic          m0_req,
   input  logic          m0_wr,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wr_data,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rd_data,
   input  logic          m1_req,
   input  logic          m1_wr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wr_data,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rd_data,
   output logic [AW-1:0] host_addr,
   output logic [DW-1:0] host_wr_data,
   output logic          host_rd_en,
   output logic          host_wr_en,
   input  logic [DW-1:0] host_rd_data,
   output logic          arb_busy,
   output logic          arb_owner
);

   arb_state_e       state_q, state_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic             wr_q, wr_d;
   logic [AW-1:0]    host_addr_q, host_addr_d;
   logic [DW-1:0]    host_wr_data_q, host_wr_data_d;
   logic             host_rd_en_q, host_rd_en_d;
   logic             host_wr_en_q, host_wr_en_d;
   logic             m0_ack_q, m0_ack_d;
   logic             m1_ack_q, m1_ack_d;
   logic [DW-1:0]    m0_rd_data_q, m0_rd_data_d;
   logic [DW-1:0]    m1_rd_data_q, m1_rd_data_d;
   logic             arb_owner_q, arb_owner_d;
   logic             last_grant_q, last_grant_d;
   logic             arb_busy_q, arb_busy_d;

   logic             win;
   logic             capture;
   logic             finish;

   host_arb_pick u_pick (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant_q),
      .winner     (win)
   );

   always_comb begin
      state_d        = state_q;
      lat_cnt_d      = lat_cnt_q;
      wr_d           = wr_q;
      host_addr_d    = host_addr_q;
      host_wr_data_d = host_wr_data_q;
      host_rd_en_d   = 1'b0;
      host_wr_en_d   = 1'b0;
      m0_ack_d       = 1'b0;
      m1_ack_d       = 1'b0;
      m0_rd_data_d   = m0_rd_data_q;
      m1_rd_data_d   = m1_rd_data_q;
      arb_owner_d    = arb_owner_q;
      last_grant_d   = last_grant_q;
      capture        = 1'b0;
      finish         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               arb_owner_d    = win;
               last_grant_d   = win;
               wr_d           = (win == M1) ? m1_wr      : m0_wr;
               host_addr_d    = (win == M1) ? m1_addr    : m0_addr;
               host_wr_data_d = (win == M1) ? m1_wr_data : m0_wr_data;
               // Strobes are registered so they are high exactly in ISSUE.
               host_wr_en_d   = wr_d;
               host_rd_en_d   = ~wr_d;
               state_d        = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (wr_q) begin
               finish = 1'b1;
            end else if (RD_LAT == 0) begin
               capture = 1'b1;
               finish  = 1'b1;
            end else begin
               lat_cnt_d = LAT_W'(RD_LAT - 1);
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q == '0) begin
               capture = 1'b1;
               finish  = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         ST_DONE: begin
            // req is deliberately ignored here so a requester that drops on
            // ack is never re-granted.
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (finish) begin
         state_d  = ST_DONE;
         m0_ack_d = (arb_owner_q == M0);
         m1_ack_d = (arb_owner_q == M1);
      end

      if (capture) begin
         if (arb_owner_q == M1) begin
            m1_rd_data_d = host_rd_data;
         end else begin
            m0_rd_data_d = host_rd_data;
         end
      end

      arb_busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge host_clk or negedge host_rst_l) begin
      if (!host_rst_l) begin
         state_q        <= ST_IDLE;
         lat_cnt_q      <= '0;
         wr_q           <= 1'b0;
         host_addr_q    <= '0;
         host_wr_data_q <= '0;
         host_rd_en_q   <= 1'b0;
         host_wr_en_q   <= 1'b0;
         m0_ack_q       <= 1'b0;
         m1_ack_q       <= 1'b0;
         m0_rd_data_q   <= '0;
         m1_rd_data_q   <= '0;
         // Owner/last grant start at master 1 so master 0 wins the first
         // contest.
         arb_owner_q    <= M1;
         last_grant_q   <= M1;
         arb_busy_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         lat_cnt_q      <= lat_cnt_d;
         wr_q           <= wr_d;
         host_addr_q    <= host_addr_d;
         host_wr_data_q <= host_wr_data_d;
         host_rd_en_q   <= host_rd_en_d;
         host_wr_en_q   <= host_wr_en_d;
         m0_ack_q       <= m0_ack_d;
         m1_ack_q       <= m1_ack_d;
         m0_rd_data_q   <= m0_rd_data_d;
         m1_rd_data_q   <= m1_rd_data_d;
         arb_owner_q    <= arb_owner_d;
         last_grant_q   <= last_grant_d;
         arb_busy_q     <= arb_busy_d;
      end
   end

   assign host_addr    = host_addr_q;
   assign host_wr_data = host_wr_data_q;
   assign host_rd_en   = host_rd_en_q;
   assign host_wr_en   = host_wr_en_q;
   assign m0_ack       = m0_ack_q;
   assign m1_ack       = m1_ack_q;
   assign m0_rd_data   = m0_rd_data_q;
   assign m1_rd_data   = m1_rd_data_q;
   assign arb_owner    = arb_owner_q;
   assign arb_busy     = arb_busy_q;

endmodule

// File: tb/tb_host_bus_arb.sv
// tb/tb_host_bus_arb.sv - self-checking bench for host_bus_arb
// Purpose: drives both masters with directed and random transfers, models the
//   host bus (memory with fixed read latency) and checks grants, strobes,
//   latencies, read data and reset behaviour against a transaction model.
// Ports: none (top-level bench). Honours HOST_ARB_FIXED_PRIO_EN.
module tb_host_bus_arb;

   localparam int RD_LAT = 2;
   localparam int AW     = 16;
   localparam int DW     = 16;
`ifdef HOST_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
   } xfer_t;

   typedef struct {
      int          cyc;
      bit          rd;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] data;
   } strobe_t;

   typedef struct {
      int          due;
      logic [15:0] data;
   } rsp_t;

   logic          host_clk;
   logic          host_rst_l;
   logic          m0_req, m0_wr, m0_ack;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wr_data, m0_rd_data;
   logic          m1_req, m1_wr, m1_ack;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wr_data, m1_rd_data;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wr_data, host_rd_data;
   logic          host_rd_en, host_wr_en;
   logic          arb_busy, arb_owner;

   int            total;
   int            bad;
   int            cyc;
   int            slog_rd;
   bit            model_last;
   logic [15:0]   exp_rd [2];
   logic [15:0]   ref_mem [64];
   logic [15:0]   bus_mem [64];
   bit            mem_init_done;
   strobe_t       strobe_log [$];
   rsp_t          rsp_q [$];
   xfer_t         q0 [$];
   xfer_t         q1 [$];

   host_bus_arb #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) dut (
      .host_clk     (host_clk),
      .host_rst_l   (host_rst_l),
      .m0_req       (m0_req),
      .m0_wr        (m0_wr),
      .m0_addr      (m0_addr),
      .m0_wr_data   (m0_wr_data),
      .m0_ack       (m0_ack),
      .m0_rd_data   (m0_rd_data),
      .m1_req       (m1_req),
      .m1_wr        (m1_wr),
      .m1_addr      (m1_addr),
      .m1_wr_data   (m1_wr_data),
      .m1_ack       (m1_ack),
      .m1_rd_data   (m1_rd_data),
      .host_addr    (host_addr),
      .host_wr_data (host_wr_data),
      .host_rd_en   (host_rd_en),
      .host_wr_en   (host_wr_en),
      .host_rd_data (host_rd_data),
      .arb_busy     (arb_busy),
      .arb_owner    (arb_owner)
   );

   initial host_clk = 1'b0;
   always #5 host_clk = ~host_clk;

   initial cyc = 0;
   always @(posedge host_clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_seed(input int i);
      return 16'(i * 263) ^ 16'h3C3C;
   endfunction

   function automatic xfer_t rand_xfer();
      xfer_t x;
      x.wr   = 1'($urandom_range(0, 1));
      x.addr = 16'($urandom);
      x.data = 16'($urandom);
      return x;
   endfunction

   // Host bus model: logs every strobe, applies writes, returns read data
   // exactly RD_LAT cycles after the read strobe and junk at all other times.
   always @(negedge host_clk) begin
      rsp_t r;
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++) bus_mem[i] = mem_seed(i);
         mem_init_done = 1'b1;
      end
      if (!host_rst_l) begin
         rsp_q = {};
         host_rd_data = 16'($urandom);
      end else begin
         if (host_rd_en || host_wr_en) begin
            strobe_log.push_back('{cyc, host_rd_en, host_wr_en, host_addr, host_wr_data});
            if (host_wr_en) bus_mem[host_addr[5:0]] = host_wr_data;
            else rsp_q.push_back('{cyc + RD_LAT, bus_mem[host_addr[5:0]]});
         end
         host_rd_data = 16'($urandom);
         if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            host_rd_data = r.data;
         end
      end
   end

   task automatic drive_masters();
      m0_req = (q0.size() != 0);
      if (q0.size() != 0) begin
         m0_wr = q0[0].wr; m0_addr = q0[0].addr; m0_wr_data = q0[0].data;
      end
      m1_req = (q1.size() != 0);
      if (q1.size() != 0) begin
         m1_wr = q1[0].wr; m1_addr = q1[0].addr; m1_wr_data = q1[0].data;
      end
   endtask

   task automatic do_reset();
      @(negedge host_clk);
      #1 host_rst_l = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(negedge host_clk);
      host_rst_l = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      model_last = 1'b1;
   endtask

   // Runs everything queued in q0/q1 and checks each ack against a
   // transaction-level prediction of grant order, timing and data.
   task automatic run_traffic(input string tag, input int max_cyc);
      bit          exp_order [$];
      int          p0, p1, c_start, last_ack, waited, exp_cyc, n;
      bit          last, w, own;
      xfer_t       t;
      strobe_t     s;
      logic [15:0] last_addr;
      p0 = q0.size(); p1 = q1.size(); last = model_last; n = 0;
      while (p0 + p1 > 0) begin
         if (p0 > 0 && p1 > 0) w = FIXED_PRIO ? 1'b0 : ~last;
         else w = (p0 > 0) ? 1'b0 : 1'b1;
         exp_order.push_back(w);
         last = w;
         if (w) p1--; else p0--;
      end
      model_last = last;
      @(negedge host_clk);
      waited = 0;
      while (arb_busy && waited < 50) begin @(negedge host_clk); waited++; end
      slog_rd = strobe_log.size();
      drive_masters();
      c_start = cyc; last_ack = -10; waited = 0; last_addr = '0;
      while ((q0.size() + q1.size()) > 0 && waited < max_cyc) begin
         @(negedge host_clk);
         waited++;
         if (m0_ack || m1_ack) begin
            own = m1_ack;
            total++;
            if (m0_ack && m1_ack) begin bad++; $display("FAIL %s both_acks got=11 want=one", tag); end
            w = own;
            if (exp_order.size() != 0) w = exp_order.pop_front();
            total++;
            if (own !== w) begin bad++; $display("FAIL %s grant got=M%0d want=M%0d", tag, own, w); end
            total++;
            if (arb_owner !== w) begin bad++; $display("FAIL %s arb_owner got=%0d want=%0d", tag, arb_owner, w); end
            total++;
            if ((own ? q1.size() : q0.size()) == 0) begin
               bad++; $display("FAIL %s spurious_ack M%0d got=ack want=none", tag, own);
            end else begin
               t = own ? q1[0] : q0[0];
               n++;
               last_addr = t.addr;
               exp_cyc = c_start + 2 + (t.wr ? 0 : RD_LAT);
               total++;
               if (cyc != exp_cyc) begin bad++; $display("FAIL %s ack_cycle got=%0d want=%0d", tag, cyc, exp_cyc); end
               if (last_ack >= 0) begin
                  total++;
                  if (cyc - last_ack < 3) begin bad++; $display("FAIL %s ack_spacing got=%0d want>=3", tag, cyc - last_ack); end
               end
               total++;
               if (slog_rd >= strobe_log.size()) begin
                  bad++; $display("FAIL %s strobe_missing got=none want=one", tag);
               end else begin
                  s = strobe_log[slog_rd];
                  slog_rd++;
                  if (s.rd && s.wr) begin bad++; $display("FAIL %s strobe_excl got=rd+wr want=one", tag); end
                  total++;
                  if (s.wr != t.wr || s.rd == t.wr) begin bad++; $display("FAIL %s strobe_kind got=rd%0d/wr%0d want_wr=%0d", tag, s.rd, s.wr, t.wr); end
                  total++;
                  if (s.cyc != c_start + 1) begin bad++; $display("FAIL %s strobe_cycle got=%0d want=%0d", tag, s.cyc, c_start + 1); end
                  total++;
                  if (s.addr !== t.addr) begin bad++; $display("FAIL %s host_addr got=%h want=%h", tag, s.addr, t.addr); end
                  if (t.wr) begin
                     total++;
                     if (s.data !== t.data) begin bad++; $display("FAIL %s host_wr_data got=%h want=%h", tag, s.data, t.data); end
                  end
               end
               if (t.wr) ref_mem[t.addr[5:0]] = t.data;
               else exp_rd[own] = ref_mem[t.addr[5:0]];
               total++;
               if (m0_rd_data !== exp_rd[0]) begin bad++; $display("FAIL %s m0_rd_data got=%h want=%h", tag, m0_rd_data, exp_rd[0]); end
               total++;
               if (m1_rd_data !== exp_rd[1]) begin bad++; $display("FAIL %s m1_rd_data got=%h want=%h", tag, m1_rd_data, exp_rd[1]); end
               if (own) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            drive_masters();
            c_start = cyc + 1;
            last_ack = cyc;
         end
      end
      total++;
      if ((q0.size() + q1.size()) != 0) begin
         bad++; $display("FAIL %s timeout pending=%0d want=0", tag, q0.size() + q1.size());
         q0 = {}; q1 = {};
         drive_masters();
      end
      total++;
      if (slog_rd != strobe_log.size()) begin
         bad++; $display("FAIL %s extra_strobes got=%0d want=0", tag, strobe_log.size() - slog_rd);
      end
      if (n > 0) begin
         total++;
         if (host_addr !== last_addr) begin bad++; $display("FAIL %s addr_hold got=%h want=%h", tag, host_addr, last_addr); end
      end
   endtask

   task automatic test_reset();
      host_rst_l = 1'b0;
      m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_data = '0;
      m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_data = '0;
      repeat (3) @(negedge host_clk);
      total += 10;
      if (host_addr !== 16'h0)    begin bad++; $display("FAIL reset host_addr got=%h want=0", host_addr); end
      if (host_wr_data !== 16'h0) begin bad++; $display("FAIL reset host_wr_data got=%h want=0", host_wr_data); end
      if (host_rd_en !== 1'b0)    begin bad++; $display("FAIL reset host_rd_en got=%b want=0", host_rd_en); end
      if (host_wr_en !== 1'b0)    begin bad++; $display("FAIL reset host_wr_en got=%b want=0", host_wr_en); end
      if (m0_ack !== 1'b0)        begin bad++; $display("FAIL reset m0_ack got=%b want=0", m0_ack); end
      if (m1_ack !== 1'b0)        begin bad++; $display("FAIL reset m1_ack got=%b want=0", m1_ack); end
      if (m0_rd_data !== 16'h0)   begin bad++; $display("FAIL reset m0_rd_data got=%h want=0", m0_rd_data); end
      if (m1_rd_data !== 16'h0)   begin bad++; $display("FAIL reset m1_rd_data got=%h want=0", m1_rd_data); end
      if (arb_busy !== 1'b0)      begin bad++; $display("FAIL reset arb_busy got=%b want=0", arb_busy); end
      if (arb_owner !== 1'b1)     begin bad++; $display("FAIL reset arb_owner got=%b want=1", arb_owner); end
      host_rst_l = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      model_last = 1'b1;
   endtask

   task automatic test_write();
      q0.push_back('{1'b1, 16'h0012, 16'hBEEF});
      run_traffic("write", 20);
   endtask

   task automatic test_read_latency();
      q0.push_back('{1'b1, 16'h0021, 16'h5A5A});
      run_traffic("read_preload", 20);
      q1.push_back('{1'b0, 16'h0021, 16'h0000});
      run_traffic("read_lat", 20);
      total++;
      if (m1_rd_data !== 16'h5A5A) begin bad++; $display("FAIL read_lat m1_rd_data got=%h want=5a5a", m1_rd_data); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         q0.push_back(rand_xfer());
         q1.push_back(rand_xfer());
      end
      run_traffic("round_robin", 60);
   endtask

   task automatic test_back_to_back();
      xfer_t x;
      x = '{1'b1, 16'h0033, 16'h1234};
      q0.push_back(x);
      q0.push_back(x);
      run_traffic("back_to_back", 30);
   endtask

   task automatic test_contention();
      int n0, n1;
      for (int r = 0; r < 6; r++) begin
         n0 = $urandom_range(0, 4);
         n1 = $urandom_range(1, 4);
         for (int k = 0; k < n0; k++) q0.push_back(rand_xfer());
         for (int k = 0; k < n1; k++) q1.push_back(rand_xfer());
         run_traffic("contention", 10 * (n0 + n1) + 20);
      end
   endtask

   task automatic test_reset_abort();
      int waited;
      @(negedge host_clk);
      waited = 0;
      while (arb_busy && waited < 50) begin @(negedge host_clk); waited++; end
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0005;
      repeat (2) @(negedge host_clk);
      total++;
      if (arb_busy !== 1'b1) begin bad++; $display("FAIL abort busy_in_wait got=%b want=1", arb_busy); end
      #1 host_rst_l = 1'b0;
      #1;
      total += 5;
      if (host_rd_en !== 1'b0) begin bad++; $display("FAIL abort host_rd_en got=%b want=0", host_rd_en); end
      if (host_wr_en !== 1'b0) begin bad++; $display("FAIL abort host_wr_en got=%b want=0", host_wr_en); end
      if (m0_ack !== 1'b0)     begin bad++; $display("FAIL abort m0_ack got=%b want=0", m0_ack); end
      if (m1_ack !== 1'b0)     begin bad++; $display("FAIL abort m1_ack got=%b want=0", m1_ack); end
      if (arb_busy !== 1'b0)   begin bad++; $display("FAIL abort arb_busy got=%b want=0", arb_busy); end
      m1_req = 1'b0;
      repeat (2) @(negedge host_clk);
      host_rst_l = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      model_last = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge host_clk);
         total++;
         if (m0_ack || m1_ack || arb_busy) begin
            bad++; $display("FAIL abort stale got=ack%b%b busy%b want=000", m1_ack, m0_ack, arb_busy);
         end
      end
      total++;
      if (m1_rd_data !== 16'h0) begin bad++; $display("FAIL abort m1_rd_data got=%h want=0", m1_rd_data); end
      q0.push_back(rand_xfer());
      q1.push_back(rand_xfer());
      run_traffic("after_abort", 40);
   endtask

   initial begin
      total = 0;
      bad = 0;
      model_last = 1'b1;
      for (int i = 0; i < 64; i++) ref_mem[i] = mem_seed(i);
      test_reset();
      test_write();
      test_read_latency();
      test_round_robin();
      test_back_to_back();
      test_contention();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
